// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS main control FSM with retired-instruction counter and illegal-opcode trap
module mc_control_fsm #(
    parameter int STATE_W         = 4,
    parameter int CNT_W           = 32,
    parameter int TRAP_ON_ILLEGAL = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [5:0]         opcode,
    input  logic               zero,
    output logic               mem_re,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               illegal_op,
    output logic               halted,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   instr_count
);
    localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_ADDIEX = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_ADDIWB = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(11);
    localparam logic [STATE_W-1:0] S_HALT   = STATE_W'(12);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic               r_live;
    logic [CNT_W-1:0]   r_count;
    logic               w_illegal;
    logic               w_retire;
    logic               w_pc_wr_uncond;
    logic               w_branch;

    assign w_illegal = !(opcode == OP_LW || opcode == OP_SW || opcode == OP_R ||
                         opcode == OP_BEQ || opcode == OP_ADDI || opcode == OP_J);
    assign w_retire  = r_state == S_MEMWB || r_state == S_MEMWR || r_state == S_ALUWB ||
                       r_state == S_BRANCH || r_state == S_ADDIWB || r_state == S_JUMP;
    assign pc_write    = w_pc_wr_uncond | (w_branch & zero);
    assign state_o     = r_state;
    assign instr_count = r_count;

    // State register; r_live holds the FSM idle in FETCH for the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_live  <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_state <= r_live ? w_next : S_FETCH;
        end
    end

    // Retired-instruction counter, bumped on every completing state (all of which return to FETCH)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (r_live && w_retire)
            r_count <= r_count + CNT_W'(1);
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = run ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = (TRAP_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // Moore output decode, everything held at zero until the FSM is live after reset
    always_comb begin
        mem_re         = 1'b0;
        mem_we         = 1'b0;
        iord           = 1'b0;
        ir_write       = 1'b0;
        pc_src         = 2'b00;
        alu_src_a      = 1'b0;
        alu_src_b      = 2'b00;
        alu_op         = 2'b00;
        reg_write      = 1'b0;
        reg_dst        = 1'b0;
        mem_to_reg     = 1'b0;
        illegal_op     = 1'b0;
        halted         = 1'b0;
        w_pc_wr_uncond = 1'b0;
        w_branch       = 1'b0;
        if (r_live) begin
            case (r_state)
                S_FETCH: begin
                    mem_re         = run;
                    ir_write       = run;
                    w_pc_wr_uncond = run;
                    alu_src_b      = run ? 2'b01 : 2'b00;
                end
                S_DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = w_illegal;
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_re = 1'b1;
                    iord   = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_we = 1'b1;
                    iord   = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    w_branch  = 1'b1;
                    pc_src    = 2'b01;
                end
                S_ADDIWB: reg_write = 1'b1;
                S_JUMP: begin
                    w_pc_wr_uncond = 1'b1;
                    pc_src         = 2'b10;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule
